// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that multiplexes NUM_REQ byte producers onto one uart_core
// register bus. Optional WAIT_DONE watchdog is built when UART_SCHED_TIMEOUT_EN is defined.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [15:0]          clks_per_bit_i,
  input  logic                 rx_en_i,
  output logic                 bus_we_o,
  output logic                 bus_ren_o,
  output logic [7:0]           bus_addr_o,
  output logic [31:0]          bus_wdata_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic [2:0]           grant_id_o,
  output logic                 err_o
);

  localparam int unsigned IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0]  ADDR_CTRL = 8'h00;
  localparam logic [7:0]  ADDR_TX   = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    WR_TX,
    WR_EN,
    WAIT_DONE,
    WR_DIS
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] last_grant_reg;
  logic [IDX_W-1:0] grant_id_reg;
  logic [7:0]       byte_reg;
  logic [15:0]      cpb_reg;

  logic [7:0]       req_byte [NUM_REQ];
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             timeout_hit;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = req_data_i[8*gi +: 8];
    end
  endgenerate

  // Scan downward so the requester nearest to last_grant+1 overwrites the others.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = {1'b0, last_grant_reg} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req_valid_i[cand[IDX_W-1:0]]) begin
        pick_idx   = cand[IDX_W-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  assign req_ready_o = (state_reg == IDLE && pick_valid && !rst_i)
                     ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx)
                     : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      grant_id_reg   <= '0;
      byte_reg       <= '0;
      cpb_reg        <= 16'd1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg      <= WR_TX;
            last_grant_reg <= pick_idx;
            grant_id_reg   <= pick_idx;
            byte_reg       <= req_byte[pick_idx];
            cpb_reg        <= (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
          end
        end
        WR_TX:     state_reg <= WR_EN;
        WR_EN:     state_reg <= WAIT_DONE;
        WAIT_DONE: begin
          if (tx_done_i || timeout_hit) begin
            state_reg <= WR_DIS;
          end
        end
        WR_DIS:    state_reg <= IDLE;
        default:   state_reg <= IDLE;
      endcase
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  logic [23:0] wd_cnt_reg;
  logic        err_reg;

  assign timeout_hit = (state_reg == WAIT_DONE) && (wd_cnt_reg == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_reg == WR_EN) begin
        wd_cnt_reg <= '0;
      end else if (state_reg == WAIT_DONE) begin
        wd_cnt_reg <= wd_cnt_reg + 24'd1;
      end
      // A done arriving on the expiry cycle takes precedence over the error.
      err_reg <= timeout_hit && !tx_done_i;
    end
  end

  assign err_o = err_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
`endif

  always_comb begin
    bus_we_o    = 1'b0;
    bus_addr_o  = 8'h00;
    bus_wdata_o = 32'h0;
    case (state_reg)
      WR_TX: begin
        bus_we_o    = 1'b1;
        bus_addr_o  = ADDR_TX;
        bus_wdata_o = {24'b0, byte_reg};
      end
      WR_EN: begin
        bus_we_o    = 1'b1;
        bus_addr_o  = ADDR_CTRL;
        bus_wdata_o = {13'b0, cpb_reg, 1'b0, rx_en_i, 1'b1};
      end
      WR_DIS: begin
        bus_we_o    = 1'b1;
        bus_addr_o  = ADDR_CTRL;
        bus_wdata_o = {13'b0, cpb_reg, 1'b0, rx_en_i, 1'b0};
      end
      default: ;
    endcase
  end

  assign bus_ren_o  = 1'b0;
  assign busy_o     = (state_reg != IDLE);
  assign grant_id_o = 3'(grant_id_reg);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a cycle-offset frame model checks every output each cycle,
// and directed scenarios pin specific values by hand.
module tb_uart_tx_sched;
  localparam int N = 4;
`ifdef UART_SCHED_TIMEOUT_EN
  localparam int          TO     = 16;
  localparam logic [23:0] TO_CYC = 24'd16;
`else
  localparam logic [23:0] TO_CYC = 24'd2000000;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid;
  logic [8*N-1:0] data;
  logic [N-1:0]   ready;
  logic [15:0]    cpb;
  logic           rx_en;
  logic           bus_we, bus_ren;
  logic [7:0]     bus_addr;
  logic [31:0]    bus_wdata;
  logic           done;
  logic           busy;
  logic [2:0]     gid;
  logic           err;

  int cmp_count  = 0;
  int fail_count = 0;
  int gid_q[$];
  time gt_q[$];

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(ready), .clks_per_bit_i(cpb), .rx_en_i(rx_en),
    .bus_we_o(bus_we), .bus_ren_o(bus_ren), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .tx_done_i(done), .busy_o(busy),
    .grant_id_o(gid), .err_o(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a granted frame at cycle g writes TX at g+1, enable at g+2, waits from g+3,
  // and disables one cycle after the done (or expiry) cycle k; IDLE resumes at k+2.
  initial begin : model
    bit          mvalid = 0;
    bit          active = 0;
    bit          to_flag = 0;
    int          c = 0, g = 0, k = -1, last = N - 1, cid = 0, win, off;
    logic [7:0]  mbyte = 8'h00;
    logic [15:0] mcpb = 16'd1;
    logic [N-1:0] e_ready;
    logic        e_we, e_err;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, ctrl;
    forever begin
      @(negedge clk);
      win = -1;
      if (!active) begin
        for (int i = 1; i <= N; i++) begin
          int j;
          j = (last + i) % N;
          if (win < 0 && valid[j]) win = j;
        end
      end
      e_ready = '0; e_we = 0; e_addr = 0; e_wdata = 0; e_err = 0;
      off = c - g;
      ctrl = {13'b0, mcpb, 1'b0, rx_en, 1'b0};
      if (!active) begin
        if (win >= 0 && !rst) e_ready = N'(1) << win;
      end else if (off == 1) begin
        e_we = 1; e_addr = 8'h04; e_wdata = {24'b0, mbyte};
      end else if (off == 2) begin
        e_we = 1; e_addr = 8'h00; e_wdata = ctrl | 32'h1;
      end else if (k >= 0 && c == k + 1) begin
        e_we = 1; e_addr = 8'h00; e_wdata = ctrl; e_err = to_flag;
      end
      if (mvalid) begin
        check("ready", 32'(ready), 32'(e_ready));
        check("bus_we", 32'(bus_we), 32'(e_we));
        check("bus_ren", 32'(bus_ren), 32'h0);
        check("bus_addr", 32'(bus_addr), 32'(e_addr));
        check("bus_wdata", bus_wdata, e_wdata);
        check("busy", 32'(busy), 32'(active));
        check("grant_id", 32'(gid), 32'(cid));
        check("err", 32'(err), 32'(e_err));
      end
      if (rst) begin
        mvalid = 1; active = 0; last = N - 1; cid = 0; mbyte = 0; mcpb = 1; k = -1; to_flag = 0;
      end else if (mvalid) begin
        if (!active) begin
          if (win >= 0) begin
            active = 1; g = c; last = win; cid = win; k = -1; to_flag = 0;
            mbyte = data[8*win +: 8];
            mcpb = (cpb == 0) ? 16'd1 : cpb;
          end
        end else if (k >= 0 && c == k + 1) begin
          active = 0;
        end else if (off >= 3 && k < 0) begin
          if (done) k = c;
`ifdef UART_SCHED_TIMEOUT_EN
          else if (off - 3 == TO - 1) begin k = c; to_flag = 1; end
`endif
        end
      end
      c++;
    end
  end

  // Requester side: a byte is accepted where valid & ready at the edge; valid then drops.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = ready & valid;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        gid_q.push_back(i);
        gt_q.push_back($time);
        $display("grant id=%0d byte=0x%02h t=%0t", i, data[8*i +: 8], $time);
      end
    end
    @(posedge clk);
    #1;
    valid = valid & ~acc;
  endtask

  // Starting in a granting IDLE cycle: done is raised d cycles after WAIT_DONE entry.
  task automatic run_frame(input int d);
    repeat (3 + d) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  initial begin : stim
    time te, terr;
    bit  seen;
    valid = '0; data = '0; cpb = '0; rx_en = 1'b0; done = 1'b0; rst = 1'b1;
    repeat (2) tick();
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_we", 32'(bus_we), 32'h0);
    check("rst_gid", 32'(gid), 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);

    // Single request from requester 2.
    rst = 1'b0; valid = 4'b0100; data[23:16] = 8'hA5; cpb = 16'd87; rx_en = 1'b0;
    #1;
    check("t1_ready", 32'(ready), 32'h4);
    tick(); #2;
    check("t1_tx_addr", 32'(bus_addr), 32'h4);
    check("t1_tx_wdata", bus_wdata, 32'h000000A5);
    tick(); #2;
    check("t1_en_addr", 32'(bus_addr), 32'h0);
    check("t1_en_wdata", bus_wdata, 32'h000002B9);
    repeat (3) tick();
    done = 1'b1;
    tick(); #2;
    done = 1'b0;
    check("t1_dis_we", 32'(bus_we), 32'h1);
    check("t1_dis_wdata", bus_wdata, 32'h000002B8);
    tick(); #2;
    check("t1_idle_busy", 32'(busy), 32'h0);

    // All four requesters valid: fair order 0..3, done 3 cycles into WAIT_DONE.
    rst = 1'b1; tick(); rst = 1'b0;
    gid_q.delete(); gt_q.delete();
    rx_en = 1'b1; cpb = 16'd10; data = {8'h13, 8'h12, 8'h11, 8'h10}; valid = 4'hF;
    repeat (4) run_frame(3);
    check("t2_grants", 32'(gid_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < gid_q.size(); i++) check("t2_order", 32'(gid_q[i]), 32'(i));
    for (int i = 1; i < gt_q.size(); i++) check("t2_spacing", 32'((gt_q[i] - gt_q[i-1]) / 10), 32'd8);

    // Done during WR_TX must not end the frame.
    valid = 4'b0010; rx_en = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (5) tick();
    #2;
    check("t3_still_busy", 32'(busy), 32'h1);
    check("t3_gid", 32'(gid), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();

    // Reset while waiting for done; next grant restarts at requester 0.
    valid = 4'b0100;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_we", 32'(bus_we), 32'h0);
    check("t4_addr", 32'(bus_addr), 32'h0);
    check("t4_wdata", bus_wdata, 32'h0);
    check("t4_gid", 32'(gid), 32'h0);
    valid = 4'hF;
    #1;
    check("t4_ready", 32'(ready), 32'h1);
    repeat (4) run_frame(1);

    // Zero baud divisor is promoted to 1.
    valid = 4'b0001; cpb = 16'd0; rx_en = 1'b0;
    tick(); tick(); #2;
    check("t5_en_wdata", bus_wdata, 32'h00000009);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();

`ifdef UART_SCHED_TIMEOUT_EN
    // Done never arrives: error pulse alongside the disable write.
    valid = 4'b0001; cpb = 16'd5;
    repeat (3) tick();
    te = $time;
    seen = 0;
    terr = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(); #2;
      if (err === 1'b1) begin
        seen = 1;
        terr = $time;
        check("t6_dis_we", 32'(bus_we), 32'h1);
        check("t6_dis_bit0", 32'(bus_wdata[0]), 32'h0);
      end
    end
    check("t6_err_seen", 32'(seen), 32'h1);
    if (seen) check("t6_err_delay", 32'((terr - te) / 10), 32'd16);
    tick(); #2;
    check("t6_err_single", 32'(err), 32'h0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end
endmodule
